// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the iterative RV32M multiply/divide unit.
// Rev 1.0
`default_nettype none

package muldiv_pkg;

   localparam int XLEN = 32;

   typedef enum logic [2:0] {
      MD_MUL    = 3'b000,
      MD_MULH   = 3'b001,
      MD_MULHSU = 3'b010,
      MD_MULHU  = 3'b011,
      MD_DIV    = 3'b100,
      MD_DIVU   = 3'b101,
      MD_REM    = 3'b110,
      MD_REMU   = 3'b111
   } funct3_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

endpackage

`default_nettype wire

// File: rtl/muldiv_special.sv
// muldiv_special: divide-by-zero / signed-overflow detection and bypass result.
// Rev 1.0
`default_nettype none

module muldiv_special
   import muldiv_pkg::*;
(
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            special,
   output logic [XLEN-1:0] result
);

   logic div_zero;
   logic overflow;

   assign div_zero = (rs2 == {XLEN{1'b0}});
   assign overflow = (rs1 == INT_MIN) && (rs2 == ALL_ONES);

   // funct3[1] selects REM over DIV, funct3[0] marks the unsigned flavours.
   always_comb begin
      special = 1'b0;
      result  = {XLEN{1'b0}};
      if (funct3[2]) begin
         if (div_zero) begin
            special = 1'b1;
            result  = funct3[1] ? rs1 : ALL_ONES;
         end else if (overflow && !funct3[0]) begin
            special = 1'b1;
            result  = funct3[1] ? {XLEN{1'b0}} : INT_MIN;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit (radix-2 shift-add, restoring divide).
// Rev 1.0
`default_nettype none

module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_start,
   input  logic            i_kill,
   input  logic [2:0]      i_funct3,
   input  logic [XLEN-1:0] i_rs1_data,
   input  logic [XLEN-1:0] i_rs2_data,
   input  logic [4:0]      i_rd_addr,
   output logic            o_busy,
   output logic            o_valid,
   output logic            o_rd_wren,
   output logic [4:0]      o_rd_addr,
   output logic [XLEN-1:0] o_result
);
   import muldiv_pkg::*;

   state_e            state;
   funct3_e           op;
   logic              neg_res;
   logic [4:0]        count;
   logic [XLEN-1:0]   opnd;
   logic [2*XLEN-1:0] acc;

   logic              a_signed, b_signed, neg_a, neg_b;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic              special;
   logic [XLEN-1:0]   special_result;

   muldiv_special u_special (
      .funct3  (i_funct3),
      .rs1     (i_rs1_data),
      .rs2     (i_rs2_data),
      .special (special),
      .result  (special_result)
   );

   // Signedness per funct3: MUL/MULH/DIV/REM both, MULHSU rs1 only, others unsigned.
   assign a_signed = i_funct3[2] ? ~i_funct3[0] : (i_funct3[1:0] != 2'b11);
   assign b_signed = i_funct3[2] ? ~i_funct3[0] : ~i_funct3[1];
   assign neg_a    = a_signed & i_rs1_data[XLEN-1];
   assign neg_b    = b_signed & i_rs2_data[XLEN-1];
   assign mag_a    = neg_a ? (~i_rs1_data + 1'b1) : i_rs1_data;
   assign mag_b    = neg_b ? (~i_rs2_data + 1'b1) : i_rs2_data;

   logic [XLEN-1:0]   addend;
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;
   logic [XLEN:0]     div_shift;
   logic [XLEN:0]     div_diff;
   logic [2*XLEN-1:0] div_next;

   // acc = {high/remainder, low/multiplier-or-quotient}; opnd = multiplicand or divisor.
   assign addend    = acc[0] ? opnd : {XLEN{1'b0}};
   assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, addend};
   assign mul_next  = {mul_sum, acc[XLEN-1:1]};
   assign div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
   assign div_diff  = div_shift - {1'b0, opnd};
   assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0],  acc[XLEN-2:0], 1'b1};

   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

   assign prod_fix = neg_res ? (~acc + 1'b1) : acc;
   assign quo_fix  = neg_res ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
   assign rem_fix  = neg_res ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];

   always_comb begin
      fix_result = prod_fix[XLEN-1:0];
      case (op)
         MD_MULH, MD_MULHSU, MD_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:              fix_result = quo_fix;
         MD_REM, MD_REMU:              fix_result = rem_fix;
         default:                      fix_result = prod_fix[XLEN-1:0];
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state     <= ST_IDLE;
         op        <= MD_MUL;
         neg_res   <= 1'b0;
         count     <= 5'd0;
         opnd      <= {XLEN{1'b0}};
         acc       <= {(2*XLEN){1'b0}};
         o_valid   <= 1'b0;
         o_rd_addr <= 5'd0;
         o_result  <= {XLEN{1'b0}};
      end else begin
         o_valid <= 1'b0;
         if (i_kill && state != ST_IDLE) begin
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (i_start && !i_kill) begin
                     op        <= funct3_e'(i_funct3);
                     o_rd_addr <= i_rd_addr;
                     // REM takes the dividend's sign; everything else the XOR of both.
                     neg_res   <= (i_funct3[2] & i_funct3[1]) ? neg_a : (neg_a ^ neg_b);
                     opnd      <= i_funct3[2] ? mag_b : mag_a;
                     acc       <= {{XLEN{1'b0}}, (i_funct3[2] ? mag_a : mag_b)};
                     count     <= 5'd31;
                     if (special) begin
                        o_result <= special_result;
                        o_valid  <= 1'b1;
                        state    <= ST_DONE;
                     end else begin
                        state <= ST_CALC;
                     end
                  end
               end
               ST_CALC: begin
                  acc   <= op[2] ? div_next : mul_next;
                  count <= count - 5'd1;
                  if (count == 5'd0) begin
                     state <= ST_FIX;
                  end
               end
               ST_FIX: begin
                  o_result <= fix_result;
                  o_valid  <= 1'b1;
                  state    <= ST_DONE;
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign o_busy    = (state != ST_IDLE);
   assign o_rd_wren = o_valid;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit (plan vectors, random ops, kill/reset).
// Rev 1.0
`default_nettype none

module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        kill = 1'b0;
   logic [2:0]  funct3 = 3'd0;
   logic [31:0] rs1 = 32'd0;
   logic [31:0] rs2 = 32'd0;
   logic [4:0]  rd = 5'd0;
   logic        busy, valid, rd_wren;
   logic [4:0]  rd_out;
   logic [31:0] result;

   muldiv_unit #(.XLEN(32)) dut (
      .i_clk      (clk),
      .i_rst      (rst_n),
      .i_start    (start),
      .i_kill     (kill),
      .i_funct3   (funct3),
      .i_rs1_data (rs1),
      .i_rs2_data (rs2),
      .i_rd_addr  (rd),
      .o_busy     (busy),
      .o_valid    (valid),
      .o_rd_wren  (rd_wren),
      .o_rd_addr  (rd_out),
      .o_result   (result)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      int          lat;
   } exp_t;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] res;
   } vec_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [31:0] last_exp = 32'd0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
      longint      sa, sb_, za;
      logic [63:0] ua, ub, p;
      logic        ovf;
      sa  = $signed(a);
      sb_ = $signed(b);
      za  = {32'd0, a};
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f3)
         3'd0: begin p = sa * sb_; return p[31:0]; end
         3'd1: begin p = sa * sb_; return p[63:32]; end
         3'd2: begin p = sa * $signed(ub); return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return 32'h8000_0000;
            p = sa / sb_; return p[31:0];
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'd0;
            p = sa % sb_; return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            p = za % longint'(ub); return p[31:0];
         end
      endcase
   endfunction

   function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
      if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
         return 1;
      return 34;
   endfunction

   task automatic advance();
      @(negedge clk);
      cyc++;
   endtask

   task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] d);
      @(negedge clk);
      start  = 1'b1;
      funct3 = f3;
      rs1    = a;
      rs2    = b;
      rd     = d;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
   endtask

   task automatic push_exp(input logic [31:0] r, input logic [4:0] d, input int lat);
      exp_t e;
      e.res = r;
      e.rd  = d;
      e.lat = lat;
      sb.push_back(e);
   endtask

   task automatic wait_result();
      exp_t e;
      while (!valid && cyc < 40) advance();
      if (!valid) begin
         check("timeout_valid", 64'd0, 64'd1);
         if (sb.size() > 0) void'(sb.pop_front());
      end else if (sb.size() == 0) begin
         check("unexpected_valid", 64'd1, 64'd0);
      end else begin
         e = sb.pop_front();
         last_exp = e.res;
         check("result", result, e.res);
         check("rd_addr", rd_out, e.rd);
         check("rd_wren", rd_wren, 1'b1);
         check("latency", cyc, e.lat);
         advance();
         check("valid_pulse", valid, 1'b0);
         check("busy_after", busy, 1'b0);
      end
   endtask

   task automatic run_vec(input vec_t v);
      start_op(v.f3, v.a, v.b, v.rd);
      push_exp(v.res, v.rd, model_lat(v.f3, v.a, v.b));
      wait_result();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t plan[13];
      vec_t v;
      logic seen;

      plan[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
      plan[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 5'd6,  32'h4000_0000};
      plan[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE};
      plan[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF};
      plan[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFD};
      plan[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFF};
      plan[6]  = '{3'd5, 32'd100,        32'd7,         5'd11, 32'd14};
      plan[7]  = '{3'd7, 32'd100,        32'd7,         5'd12, 32'd2};
      plan[8]  = '{3'd4, 32'd5,          32'd0,         5'd13, 32'hFFFF_FFFF};
      plan[9]  = '{3'd6, 32'd5,          32'd0,         5'd14, 32'd5};
      plan[10] = '{3'd5, 32'd5,          32'd0,         5'd15, 32'hFFFF_FFFF};
      plan[11] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd0,  32'h8000_0000};
      plan[12] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'd0};

      repeat (2) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_valid", valid, 1'b0);
      check("rst_wren", rd_wren, 1'b0);
      check("rst_rd", rd_out, 5'd0);
      check("rst_result", result, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 13; i++) run_vec(plan[i]);

      for (int i = 0; i < 10; i++) begin
         v.f3 = 3'($urandom_range(0, 7));
         v.a  = $urandom;
         v.b  = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
         v.rd = 5'($urandom_range(0, 31));
         v.res = model(v.f3, v.a, v.b);
         run_vec(v);
      end

      // A second start mid-operation must be dropped.
      start_op(3'd0, 32'd6, 32'd7, 5'd3);
      push_exp(32'd42, 5'd3, 34);
      while (cyc < 10) advance();
      start = 1'b1; funct3 = 3'd5; rs1 = 32'd100; rs2 = 32'd7; rd = 5'd9;
      advance();
      start = 1'b0;
      wait_result();
      seen = 1'b0;
      repeat (40) begin
         advance();
         if (valid || busy) seen = 1'b1;
      end
      check("no_queue", seen, 1'b0);

      // Kill at cycle 20: back to idle, no strobe, result untouched.
      start_op(3'd5, 32'd1000, 32'd3, 5'd7);
      while (cyc < 20) advance();
      kill = 1'b1;
      advance();
      kill = 1'b0;
      check("kill_busy", busy, 1'b0);
      check("kill_valid", valid, 1'b0);
      check("kill_result", result, last_exp);
      seen = 1'b0;
      repeat (40) begin
         advance();
         if (valid) seen = 1'b1;
      end
      check("kill_no_valid", seen, 1'b0);

      // Asynchronous reset in the middle of a DIV.
      start_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd11);
      while (cyc < 15) advance();
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_valid", valid, 1'b0);
      check("mid_rst_wren", rd_wren, 1'b0);
      check("mid_rst_rd", rd_out, 5'd0);
      check("mid_rst_result", result, 32'd0);
      repeat (2) advance();
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         advance();
         if (valid) seen = 1'b1;
      end
      check("rst_no_valid", seen, 1'b0);

      v = '{3'd0, 32'd3, 32'd4, 5'd2, 32'd12};
      run_vec(v);

      check("scoreboard_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide execution unit, downstream of regfile.
- Consumes the regfile's o_rs1_data/o_rs2_data operands plus decoded funct3 and rd address.
- Returns a result, rd address and write-enable to the regfile write port (i_rd_data/i_rd_addr/i_rd_wren).
- The core stalls on o_busy; multi-cycle so the single-cycle datapath avoids a 32x32 combinational multiplier/divider.

Parameters:
XLEN, 32, operand/result width (only 32 supported)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous active-low reset
i_start  in  1  request; accepted when i_start=1 and o_busy=0
i_kill  in  1  synchronous abort of in-flight op
i_funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
i_rs1_data  in  XLEN  operand A (dividend / multiplicand)
i_rs2_data  in  XLEN  operand B (divisor / multiplier)
i_rd_addr  in  5  destination register
o_busy  out  1  high whenever state != IDLE
o_valid  out  1  one-cycle result strobe
o_rd_wren  out  1  equals o_valid
o_rd_addr  out  5  latched destination
o_result  out  XLEN  result; held until next accept

Behaviour:
- Reset (i_rst=0, asynchronous): state IDLE. o_busy, o_valid, o_rd_wren, o_rd_addr and o_result all 0. Internal counter and accumulators cleared.
- Accept edge (E0): latch funct3, rd_addr, operand magnitudes and result sign.
  - Signed ops: DIV/REM/MULH use both operands signed; MULHSU treats rs1 signed, rs2 unsigned.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE -> CALC on accept, unless a special case applies. Special cases go IDLE -> DONE with the result loaded directly.
- CALC: 32 iterations, 5-bit counter 31 down to 0.
  - Multiply: radix-2 shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract; quotient and remainder 32 bits each.
  - At count 0 go to FIX.
- FIX (1 cycle): apply sign and select the result.
  - MUL: low 32 bits. MULH/MULHSU/MULHU: high 32 bits of the 64-bit two's-complement product.
  - DIV/DIVU: quotient, negated if operand signs differ (signed ops only).
  - REM/REMU: remainder, taking the dividend's sign. Then go to DONE.
- DONE: o_valid=o_rd_wren=1 for exactly one cycle; o_busy still 1. Go to IDLE next edge.
- Latency: normal ops assert o_valid in the 34th cycle after E0. Special cases assert it in the cycle right after E0.
- Special cases (div/rem only):
  - Divisor 0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- i_start while o_busy=1 is ignored; there is no queue.
- i_kill (any non-IDLE state) -> IDLE next edge. No o_valid; o_result keeps its old value. i_kill has priority over i_start in the same cycle.
- i_kill in IDLE has no effect; i_start in the same cycle is not accepted.
- Reset asserted mid-operation: immediate return to IDLE with reset values; no o_valid.
- Arithmetic is modulo 2^32; no exceptions raised.
- rd=x0 is passed through unchanged; the regfile discards the write.

Decomposition:
- Package muldiv_pkg holds:
  - XLEN.
  - funct3 enum: MD_MUL through MD_REMU.
  - FSM state enum: ST_IDLE, ST_CALC, ST_FIX, ST_DONE.
  - Constants ALL_ONES and INT_MIN.
- One combinational sub-module, muldiv_special. It detects divide-by-zero and overflow and produces the bypass result, so the corner-case logic can be tested standalone.

Test Plan:
- MUL 7 x 0xFFFFFFFD -> o_result 0xFFFFFFEB; o_valid single pulse exactly 34 cycles after accept; o_rd_addr equals the latched rd (e.g. 5).
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIVU 5/0 -> 0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0. Each gives o_valid 1 cycle after accept.
- New i_start at cycle 10 of an op is ignored (result still from the first op). i_kill at cycle 20 -> o_busy low next cycle, no o_valid, o_result unchanged.
- i_rst low at cycle 15 of a DIV -> all outputs 0 immediately, no o_valid. After release, MUL 3x4 -> 12.
